// File: rtl/pe_ctrl.sv
// pe_ctrl: sequences weight/activation loads into a conv PE, runs one
// compute per output row and hands each partial sum to a consumer.
module pe_ctrl #(
  parameter int DATA_BITWIDTH = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int ACT_SIZE = 5,
  parameter int NUM_OUT = ACT_SIZE - KERNEL_SIZE + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic abort,
  output logic busy,
  output logic done,
  input  logic wght_valid,
  output logic wght_ready,
  input  logic [DATA_BITWIDTH-1:0] wght_data,
  input  logic act_valid,
  output logic act_ready,
  input  logic [DATA_BITWIDTH-1:0] act_data,
  output logic pe_load_en_wght,
  output logic pe_load_en_act,
  output logic pe_start,
  output logic [DATA_BITWIDTH-1:0] pe_filt_in,
  output logic [DATA_BITWIDTH-1:0] pe_act_in,
  input  logic pe_load_done,
  input  logic pe_compute_done,
  input  logic [DATA_BITWIDTH-1:0] pe_out,
  output logic psum_valid,
  input  logic psum_ready,
  output logic [DATA_BITWIDTH-1:0] psum_data,
  output logic [1:0] psum_idx
);

  localparam int NWORDS = ACT_SIZE * ACT_SIZE;
  localparam int CW = $clog2(NWORDS + 1);
  localparam int RW = $clog2(NUM_OUT + 1);
  localparam logic [CW-1:0] W_LAST = CW'(KERNEL_SIZE * KERNEL_SIZE - 1);
  localparam logic [CW-1:0] A_LAST = CW'(NWORDS - 1);
  localparam logic [CW-1:0] WRAP_LAST = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(NUM_OUT - 1);

  typedef enum logic [3:0] {
    IDLE, COL_W, BURST_W, WAIT_WL,
    COL_A, BURST_A, WAIT_AL, START,
    WAIT_CD, OUT, WRAP, DONE
  } state_t;

  state_t state, state_nxt;
  logic [CW-1:0] count;
  logic [RW-1:0] row;
  logic [DATA_BITWIDTH-1:0] mem [NWORDS];
  logic cd_q;
  logic cd_rise;
  logic w_fire;
  logic a_fire;

  assign cd_rise = pe_compute_done && !cd_q;
  assign w_fire = wght_valid && wght_ready;
  assign a_fire = act_valid && act_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (run) state_nxt = COL_W;
        COL_W:   if (w_fire && count == W_LAST) state_nxt = BURST_W;
        BURST_W: if (count == W_LAST) state_nxt = WAIT_WL;
        WAIT_WL: if (pe_load_done) state_nxt = COL_A;
        COL_A:   if (a_fire && count == A_LAST) state_nxt = BURST_A;
        BURST_A: if (count == A_LAST) state_nxt = WAIT_AL;
        WAIT_AL: if (pe_load_done) state_nxt = START;
        START:   state_nxt = WAIT_CD;
        WAIT_CD: if (cd_rise) state_nxt = OUT;
        OUT: begin
          if (psum_ready)
            state_nxt = (row == ROW_LAST) ? WRAP : START;
        end
        WRAP:    if (count == WRAP_LAST) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    wght_ready = 1'b0;
    act_ready = 1'b0;
    pe_load_en_wght = 1'b0;
    pe_load_en_act = 1'b0;
    pe_start = 1'b0;
    pe_filt_in = '0;
    pe_act_in = '0;
    psum_valid = 1'b0;
    unique case (state)
      IDLE: ;
      COL_W: begin
        busy = 1'b1;
        wght_ready = 1'b1;
      end
      BURST_W: begin
        busy = 1'b1;
        pe_load_en_wght = (count == '0);
        pe_filt_in = mem[count];
      end
      COL_A: begin
        busy = 1'b1;
        act_ready = 1'b1;
      end
      BURST_A: begin
        busy = 1'b1;
        pe_load_en_act = (count == '0);
        pe_act_in = mem[count];
      end
      START: begin
        busy = 1'b1;
        pe_start = 1'b1;
      end
      OUT: begin
        busy = 1'b1;
        psum_valid = 1'b1;
      end
      WRAP: begin
        busy = 1'b1;
        pe_start = (count == '0);
      end
      DONE: done = 1'b1;
      default: busy = (state != IDLE);
    endcase
  end

  // count serves collect, burst and wrap phases; each phase leaves it at 0
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      row <= '0;
      cd_q <= 1'b0;
      psum_data <= '0;
      psum_idx <= '0;
    end else begin
      cd_q <= pe_compute_done;
      if (abort) begin
        count <= '0;
        row <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (run) begin
              count <= '0;
              row <= '0;
            end
          end
          COL_W: begin
            if (w_fire)
              count <= (count == W_LAST) ? '0 : count + 1'b1;
          end
          BURST_W: count <= (count == W_LAST) ? '0 : count + 1'b1;
          COL_A: begin
            if (a_fire)
              count <= (count == A_LAST) ? '0 : count + 1'b1;
          end
          BURST_A: count <= (count == A_LAST) ? '0 : count + 1'b1;
          WAIT_AL: if (pe_load_done) row <= '0;
          WAIT_CD: begin
            if (cd_rise) begin
              psum_data <= pe_out;
              psum_idx <= 2'(row);
            end
          end
          OUT: if (psum_ready) row <= row + 1'b1;
          WRAP: count <= (count == WRAP_LAST) ? '0 : count + 1'b1;
          DONE: count <= '0;
          default: ;
        endcase
      end
    end
  end

  // one buffer, reused: weights first, then overwritten by activations
  always_ff @(posedge clk) begin
    if (w_fire) mem[count] <= wght_data;
    else if (a_fire) mem[count] <= act_data;
  end

endmodule

// File: tb/tb_pe_ctrl.sv
// tb_pe_ctrl: randomized jobs against a conv reference model,
// with a queue scoreboard on the psum channel.
module tb_pe_ctrl;

  localparam int K = 3;
  localparam int A = 5;
  localparam int NO = A - K + 1;

  logic clk;
  logic reset;
  logic run;
  logic abort;
  logic busy;
  logic done;
  logic wght_valid;
  logic wght_ready;
  logic [15:0] wght_data;
  logic act_valid;
  logic act_ready;
  logic [15:0] act_data;
  logic pe_load_en_wght;
  logic pe_load_en_act;
  logic pe_start;
  logic [15:0] pe_filt_in;
  logic [15:0] pe_act_in;
  logic pe_load_done;
  logic pe_compute_done;
  logic [15:0] pe_out;
  logic psum_valid;
  logic psum_ready;
  logic [15:0] psum_data;
  logic [1:0] psum_idx;

  pe_ctrl dut (
    .clk(clk), .reset(reset), .run(run), .abort(abort),
    .busy(busy), .done(done),
    .wght_valid(wght_valid), .wght_ready(wght_ready),
    .wght_data(wght_data),
    .act_valid(act_valid), .act_ready(act_ready),
    .act_data(act_data),
    .pe_load_en_wght(pe_load_en_wght),
    .pe_load_en_act(pe_load_en_act),
    .pe_start(pe_start),
    .pe_filt_in(pe_filt_in), .pe_act_in(pe_act_in),
    .pe_load_done(pe_load_done),
    .pe_compute_done(pe_compute_done),
    .pe_out(pe_out),
    .psum_valid(psum_valid), .psum_ready(psum_ready),
    .psum_data(psum_data), .psum_idx(psum_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int start_cnt = 0;
  int wrap_cnt = 0;
  bit stall_arm = 0;
  bit rand_ready = 0;

  logic [15:0] jw [K*K];
  logic [15:0] ja [A*A];

  typedef struct {
    logic [1:0] idx;
    logic [15:0] data;
  } exp_t;
  exp_t q[$];

  function automatic void check(input string name,
                                input logic [31:0] got,
                                input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  function automatic logic [15:0] ref_row(input int r);
    int s;
    s = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        s += int'(jw[i*K+j]) * int'(ja[(r+i)*A+j]);
    return 16'(s);
  endfunction

  // PE model: captures bursts, computes row r of the valid conv column 0
  logic [15:0] pw [K*K];
  logic [15:0] pa [A*A];
  int wk = -1;
  int ak = -1;
  int prow = 0;
  int lat = 0;
  logic [15:0] res;

  always @(posedge clk) begin
    pe_load_done <= 1'b0;
    if (reset) begin
      wk = -1;
      ak = -1;
      prow = 0;
      lat = 0;
      pe_compute_done <= 1'b0;
      pe_out <= '0;
    end else begin
      if (pe_load_en_wght) begin
        pw[0] = pe_filt_in;
        wk = 1;
      end else if (wk > 0) begin
        pw[wk] = pe_filt_in;
        wk++;
        if (wk == K*K) begin
          wk = -1;
          pe_load_done <= 1'b1;
        end
      end
      if (pe_load_en_act) begin
        pa[0] = pe_act_in;
        ak = 1;
      end else if (ak > 0) begin
        pa[ak] = pe_act_in;
        ak++;
        if (ak == A*A) begin
          ak = -1;
          pe_load_done <= 1'b1;
        end
      end
      if (pe_start) begin
        start_cnt++;
        if (prow == NO) begin
          prow = 0;
          wrap_cnt++;
        end else begin
          int s;
          s = 0;
          for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
              s += int'(pw[i*K+j]) * int'(pa[(prow+i)*A+j]);
          res = 16'(s);
          prow++;
          pe_compute_done <= 1'b0;
          lat = 3 + int'($urandom_range(0, 3));
        end
      end else if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          pe_compute_done <= 1'b1;
          pe_out <= res;
        end
      end
    end
  end

  initial begin
    psum_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_arm && psum_valid && psum_idx == 2'd1) begin
        psum_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        psum_ready = 1'b1;
        stall_arm = 0;
      end else begin
        psum_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // scoreboard monitor plus hold-while-stalled checks
  bit stall_q = 0;
  logic [1:0] s_idx;
  logic [15:0] s_data;

  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
    if (reset) begin
      stall_q = 0;
    end else begin
      if (stall_q) begin
        check("hold_valid", 32'(psum_valid), 1);
        check("hold_data", 32'(psum_data), 32'(s_data));
        check("hold_idx", 32'(psum_idx), 32'(s_idx));
      end
      if (psum_valid) check("start_in_out", 32'(pe_start), 0);
      if (psum_valid && psum_ready) begin
        stall_q = 0;
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_psum: idx %0d data %0d",
                   psum_idx, psum_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("psum_idx", 32'(psum_idx), 32'(e.idx));
          check("psum_data", 32'(psum_data), 32'(e.data));
        end
      end else if (psum_valid) begin
        stall_q = 1;
        s_idx = psum_idx;
        s_data = psum_data;
      end else begin
        stall_q = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (pe_load_en_wght) begin
      for (int k = 0; k < K*K; k++) begin
        if (k > 0) @(negedge clk);
        if (!busy) break;
        check("filt_in", 32'(pe_filt_in), 32'(jw[k]));
        if (k > 0) check("load_en_w", 32'(pe_load_en_wght), 0);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (pe_load_en_act) begin
      for (int k = 0; k < A*A; k++) begin
        if (k > 0) @(negedge clk);
        if (!busy) break;
        check("act_in", 32'(pe_act_in), 32'(ja[k]));
        if (k > 0) check("load_en_a", 32'(pe_load_en_act), 0);
      end
    end
  end

  task automatic check_quiet(input string name);
    check(name, 32'({busy, done, wght_ready, act_ready,
                     pe_load_en_wght, pe_load_en_act,
                     pe_start, psum_valid}), 0);
    check({name, "_pe"}, {pe_filt_in, pe_act_in}, 0);
  endtask

  task automatic fill_random(input bit zero_w);
    for (int i = 0; i < K*K; i++)
      jw[i] = zero_w ? 16'd0 : 16'($urandom_range(0, 255));
    for (int i = 0; i < A*A; i++)
      ja[i] = 16'($urandom_range(0, 255));
  endtask

  task automatic start_job();
    @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 0);
    run = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b0;
    check("busy_rise", 32'(busy), 1);
  endtask

  // mode 0: always valid, 1: every other cycle, 2: random plus junk
  task automatic send_words(input bit is_act, input int mode);
    int n;
    int i;
    int g;
    bit v;
    n = is_act ? A*A : K*K;
    i = 0;
    g = 0;
    while (i < n && g < 4000) begin
      v = (mode == 0) ? 1'b1 :
          (mode == 1) ? (g % 2 == 0) : ($urandom_range(0, 2) != 0);
      if (is_act) begin
        act_valid = v;
        act_data = v ? ja[i] : 16'hdead;
        wght_valid = (mode == 2) && ($urandom_range(0, 1) == 1);
        wght_data = 16'hbeef;
      end else begin
        wght_valid = v;
        wght_data = v ? jw[i] : 16'hdead;
        act_valid = (mode == 2) && ($urandom_range(0, 1) == 1);
        act_data = 16'hbeef;
      end
      @(negedge clk);
      if (v && (is_act ? act_ready : wght_ready)) i++;
      @(posedge clk);
      #1;
      g++;
    end
    wght_valid = 1'b0;
    act_valid = 1'b0;
    if (i < n) check("send_timeout", 32'(i), 32'(n));
  endtask

  task automatic finish_job(input int d0, input int s0, input int w0);
    int g;
    g = 0;
    while (done_cnt == d0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    check("done_pulses", 32'(done_cnt - d0), 1);
    check("start_pulses", 32'(start_cnt - s0), NO + 1);
    check("wrap_pulses", 32'(wrap_cnt - w0), 1);
    check("busy_end", 32'(busy), 0);
    check("queue_drained", 32'(q.size()), 0);
  endtask

  task automatic normal_job(input int wmode, input int amode,
                            input bit const_exp);
    int d0;
    int s0;
    int w0;
    d0 = done_cnt;
    s0 = start_cnt;
    w0 = wrap_cnt;
    if (const_exp) begin
      q.push_back('{2'd0, 16'd411});
      q.push_back('{2'd1, 16'd636});
      q.push_back('{2'd2, 16'd861});
    end else begin
      for (int r = 0; r < NO; r++)
        q.push_back('{2'(r), ref_row(r)});
    end
    start_job();
    send_words(0, wmode);
    run = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b0;
    send_words(1, amode);
    finish_job(d0, s0, w0);
  endtask

  task automatic abort_job();
    int d0;
    fill_random(0);
    d0 = done_cnt;
    start_job();
    send_words(0, 0);
    send_words(1, 0);
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check_quiet("abort_quiet");
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 0);
  endtask

  task automatic reset_job();
    int g;
    fill_random(0);
    start_job();
    send_words(0, 0);
    send_words(1, 0);
    g = 0;
    while (!pe_start && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("saw_start", 32'(pe_start), 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_quiet("rst_quiet");
    check("rst_psum", {14'd0, psum_idx, psum_data}, 0);
    q.delete();
    repeat (5) @(posedge clk);
  endtask

  initial begin
    reset = 1'b1;
    run = 1'b0;
    abort = 1'b0;
    wght_valid = 1'b0;
    wght_data = '0;
    act_valid = 1'b0;
    act_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset_quiet");
    check("reset_psum", {14'd0, psum_idx, psum_data}, 0);
    reset = 1'b0;

    for (int i = 0; i < K*K; i++) jw[i] = 16'(i + 1);
    for (int i = 0; i < A*A; i++) ja[i] = 16'(i + 1);
    normal_job(0, 0, 1);

    fill_random(0);
    stall_arm = 1;
    normal_job(1, 0, 0);
    check("stall_used", 32'(stall_arm), 0);

    abort_job();
    fill_random(0);
    normal_job(0, 0, 0);

    rand_ready = 1;
    fill_random(0);
    normal_job(2, 2, 0);

    reset_job();

    fill_random(0);
    normal_job(0, 2, 0);
    fill_random(1);
    normal_job(0, 0, 0);

    for (int n = 0; n < 3; n++) begin
      fill_random(0);
      normal_job(2, 2, 0);
    end

    check("final_queue", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
